// File: rtl/arm_isa_pkg.sv
// Shared ISA encodings for the encoder and the ID-stage decoder.
// Modes, opcodes, ALU commands and field positions.
package arm_isa_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int COND_LSB = 28;
  localparam int MODE_LSB = 26;
  localparam int IMM_BIT  = 25;
  localparam int OPC_LSB  = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;

  typedef struct packed {
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [3:0]  cond;
    logic        imm_i;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] shifter;
    logic [23:0] imm24;
  } enc_req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_res_t;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO with registered head.
// in_ready depends only on the entry count.
module instr_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = r_head;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head/tail update; push+pop only occurs at count 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_pop, w_push})
        2'b01: begin
          if (r_cnt == 2'd0) r_head <= in_data;
          else               r_tail <= in_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b10: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: r_head <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// Packs control bundles into 32-bit instruction words
// tagged with an auto-incrementing byte address.
module arm_instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              wb_en,
  input  logic              b,
  input  logic              s,
  input  logic [3:0]        cond,
  input  logic              imm_i,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       shifter,
  input  logic [23:0]       imm24,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              err_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              illegal_seen
);

  function automatic enc_res_t encode(enc_req_t r);
    enc_res_t   res;
    logic [3:0] opc;
    logic       nop;
    res = '0;
    opc = OP_AND;
    nop = 1'b0;
    case ({r.mem_r_en, r.mem_w_en, r.b})
      3'b000: begin
        res.legal = r.wb_en;
        case (r.exe_cmd)
          CMD_NOP: begin nop = 1'b1; res.legal = !r.wb_en; end
          CMD_MOV: opc = OP_MOV;
          CMD_MVN: opc = OP_MVN;
          CMD_ADD: opc = OP_ADD;
          CMD_ADC: opc = OP_ADC;
          CMD_SBC: opc = OP_SBC;
          CMD_ORR: opc = OP_ORR;
          CMD_EOR: opc = OP_EOR;
          CMD_SUB: begin
            opc = r.wb_en ? OP_SUB : OP_CMP;
            res.legal = 1'b1;
          end
          CMD_AND: begin
            opc = r.wb_en ? OP_AND : OP_TST;
            res.legal = 1'b1;
          end
          default: res.legal = 1'b0;
        endcase
        if (nop)
          res.word = {r.cond, MODE_NOP, 26'b0};
        else
          res.word = {r.cond, MODE_DP, r.imm_i, opc, r.s,
                      r.rn, r.rd, r.shifter};
      end
      3'b100: begin
        res.legal = r.wb_en;
        res.word  = {r.cond, MODE_MEM, r.imm_i, OP_ADD, 1'b1,
                     r.rn, r.rd, r.shifter};
      end
      3'b010: begin
        res.legal = !r.wb_en;
        res.word  = {r.cond, MODE_MEM, r.imm_i, OP_ADD, 1'b0,
                     r.rn, r.rd, r.shifter};
      end
      3'b001: begin
        res.legal = !r.wb_en;
        res.word  = {r.cond, MODE_BR, 1'b1, 1'b0, r.imm24};
      end
      default: res.legal = 1'b0;
    endcase
    if (!res.legal) res.word = '0;
    return res;
  endfunction

  enc_req_t          w_req;
  enc_res_t          w_res;
  logic              w_fire;
  logic              w_push;
  logic [ADDR_W-1:0] w_tag;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ill;

  assign w_req = {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s,
                  cond, imm_i, rn, rd, shifter, imm24};
  assign w_res  = encode(w_req);
  assign w_fire = in_valid && in_ready;
  assign w_push = w_fire && w_res.legal;
  assign w_tag  = base_load ? base_addr : r_addr;
  assign illegal_seen = r_ill;

  // Address counter: base_load wins, push advances past the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_addr <= '0;
    else if (w_push)    r_addr <= w_tag + ADDR_W'(4);
    else if (base_load) r_addr <= base_addr;
  end

  // Sticky illegal flag; a new illegal request beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_ill <= 1'b0;
    else if (w_fire && !w_res.legal) r_ill <= 1'b1;
    else if (err_clr)                r_ill <= 1'b0;
  end

  instr_fifo2 #(.W(32 + ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_push),
    .in_ready  (in_ready),
    .in_data   ({w_res.word, w_tag}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_word, out_addr})
  );

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed bench for arm_instr_encoder.
// Hand-computed words/addresses, single check task.
module tb_arm_instr_encoder;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready;
  logic [3:0]    exe_cmd;
  logic          mem_r_en, mem_w_en, wb_en, b, s;
  logic [3:0]    cond;
  logic          imm_i;
  logic [3:0]    rn, rd;
  logic [11:0]   shifter;
  logic [23:0]   imm24;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          err_clr;
  logic          out_valid, out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          illegal_seen;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arm_instr_encoder #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exe_cmd      (exe_cmd),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .wb_en        (wb_en),
    .b            (b),
    .s            (s),
    .cond         (cond),
    .imm_i        (imm_i),
    .rn           (rn),
    .rd           (rd),
    .shifter      (shifter),
    .imm24        (imm24),
    .base_load    (base_load),
    .base_addr    (base_addr),
    .err_clr      (err_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_addr     (out_addr),
    .illegal_seen (illegal_seen)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    exe_cmd  = 4'h0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    wb_en    = 1'b0;
    b        = 1'b0;
    s        = 1'b0;
    cond     = 4'hE;
    imm_i    = 1'b0;
    rn       = 4'h0;
    rd       = 4'h0;
    shifter  = 12'h0;
    imm24    = 24'h0;
  endtask

  task automatic add_req();
    clr();
    exe_cmd = 4'b0010;
    wb_en   = 1'b1;
    s       = 1'b1;
    imm_i   = 1'b1;
    rn      = 4'h1;
    rd      = 4'h2;
    shifter = 12'h005;
  endtask

  // Called away from posedge; accepted at the next edge with in_ready.
  task automatic send();
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic expect_out(input string tag,
                            input logic [31:0] w,
                            input logic [AW-1:0] a);
    @(negedge clk);
    check({tag, "_v"}, 64'(out_valid), 64'(1));
    check({tag, "_w"}, 64'(out_word), 64'(w));
    check({tag, "_a"}, 64'(out_addr), 64'(a));
  endtask

  initial begin
    clr();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    base_load = 1'b0;
    base_addr = '0;
    err_clr   = 1'b0;
    #12;
    check("rst_ov", 64'(out_valid), 64'(0));
    check("rst_ow", 64'(out_word), 64'(0));
    check("rst_oa", 64'(out_addr), 64'(0));
    check("rst_ir", 64'(in_ready), 64'(1));
    check("rst_il", 64'(illegal_seen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    add_req();
    send();
    expect_out("add", 32'hE2912005, 32'h0);

    clr(); exe_cmd = 4'b0100; s = 1'b1; rn = 4'h3; shifter = 12'h004;
    send();
    expect_out("cmp", 32'hE1530004, 32'h4);

    wb_en = 1'b1; s = 1'b0;
    send();
    expect_out("sub", 32'hE0430004, 32'h8);

    clr(); mem_r_en = 1'b1; wb_en = 1'b1; rd = 4'h1; shifter = 12'h008;
    send();
    expect_out("ldr", 32'hE4901008, 32'hC);

    clr(); mem_w_en = 1'b1; rd = 4'h1; shifter = 12'h008;
    send();
    expect_out("str", 32'hE4801008, 32'h10);

    clr(); b = 1'b1; imm24 = 24'hFFFFFE;
    send();
    expect_out("br", 32'hEAFFFFFE, 32'h14);

    clr();
    send();
    expect_out("nop", 32'hEC000000, 32'h18);

    clr(); exe_cmd = 4'b1001; wb_en = 1'b1; rd = 4'h5; shifter = 12'h0A3;
    send();
    expect_out("mvn", 32'hE1E050A3, 32'h1C);

    clr(); exe_cmd = 4'b0110; s = 1'b1; rn = 4'h7;
    send();
    expect_out("tst", 32'hE1170000, 32'h20);

    // Fill the FIFO with the sink stalled.
    @(negedge clk);
    out_ready = 1'b0;
    base_load = 1'b1;
    base_addr = 32'h100;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    add_req();
    send();
    clr(); exe_cmd = 4'b0001; wb_en = 1'b1; rd = 4'h3; shifter = 12'h0FF;
    send();
    @(negedge clk);
    check("full_v", 64'(out_valid), 64'(1));
    check("full_a", 64'(out_addr), 64'(32'h100));
    check("full_w", 64'(out_word), 64'(32'hE2912005));
    check("full_ir", 64'(in_ready), 64'(0));
    clr(); exe_cmd = 4'b0111; wb_en = 1'b1; rn = 4'h1; rd = 4'h1;
    shifter = 12'h002;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_a", 64'(out_addr), 64'(32'h100));
    check("hold_ir", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pop1_a", 64'(out_addr), 64'(32'h104));
    check("pop1_w", 64'(out_word), 64'(32'hE1A030FF));
    check("pop1_ir", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_v", 64'(out_valid), 64'(1));
    check("pp_a", 64'(out_addr), 64'(32'h108));
    check("pp_w", 64'(out_word), 64'(32'hE1811002));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_v", 64'(out_valid), 64'(0));

    // Illegal requests: dropped, flag set, counter untouched.
    clr(); mem_r_en = 1'b1; b = 1'b1;
    send();
    @(negedge clk);
    check("ill_mb_flag", 64'(illegal_seen), 64'(1));
    check("ill_mb_v", 64'(out_valid), 64'(0));
    clr(); mem_r_en = 1'b1;
    send();
    @(negedge clk);
    check("ill_ldr_v", 64'(out_valid), 64'(0));
    clr(); mem_w_en = 1'b1; wb_en = 1'b1;
    send();
    @(negedge clk);
    check("ill_str_v", 64'(out_valid), 64'(0));
    clr(); exe_cmd = 4'hB; wb_en = 1'b1;
    send();
    @(negedge clk);
    check("ill_cmd_v", 64'(out_valid), 64'(0));
    clr(); wb_en = 1'b1;
    send();
    @(negedge clk);
    check("ill_nopwb_v", 64'(out_valid), 64'(0));
    clr(); exe_cmd = 4'b0010;
    send();
    @(negedge clk);
    check("ill_addwb_v", 64'(out_valid), 64'(0));
    clr(); mem_r_en = 1'b1; b = 1'b1;
    err_clr = 1'b1;
    send();
    err_clr = 1'b0;
    @(negedge clk);
    check("setwins", 64'(illegal_seen), 64'(1));
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("errclr", 64'(illegal_seen), 64'(0));
    add_req();
    send();
    expect_out("post_ill", 32'hE2912005, 32'h10C);

    // Counter wrap.
    base_load = 1'b1;
    base_addr = 32'hFFFFFFFC;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    send();
    expect_out("wrap0", 32'hE2912005, 32'hFFFFFFFC);
    send();
    expect_out("wrap1", 32'hE2912005, 32'h0);

    // base_load together with a push.
    base_load = 1'b1;
    base_addr = 32'h200;
    send();
    base_load = 1'b0;
    expect_out("bl_push", 32'hE2912005, 32'h200);
    send();
    expect_out("bl_next", 32'hE2912005, 32'h204);

    // Asynchronous reset with a full FIFO and flag set.
    clr(); b = 1'b1; mem_w_en = 1'b1;
    send();
    @(negedge clk);
    out_ready = 1'b0;
    add_req();
    send();
    send();
    @(negedge clk);
    check("pre_rst_ir", 64'(in_ready), 64'(0));
    check("pre_rst_il", 64'(illegal_seen), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", 64'(out_valid), 64'(0));
    check("arst_ir", 64'(in_ready), 64'(1));
    check("arst_il", 64'(illegal_seen), 64'(0));
    check("arst_oa", 64'(out_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send();
    expect_out("after_rst", 32'hE2912005, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
